cal_seq: RTL and testbench
==========================

Name: cal_seq

Overview:
- Micro-sequencer for the calculator datapath.
- Accepts one-shot commands (opcode + address).
- Drives the data-bus source select `dmux` and the memory read/write strobes.
- Drives the accumulator load enable and ALU op.
- Sits between the command source (testbench/CPU stub) and the dmux/mem/acc datapath.
- One command in flight at a time.

Parameters:
- AW, 4, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- opcode  in  3  command code; sampled with start.
- addr  in  AW  memory address; sampled with start.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at command completion.
- dmux  out  2  data-bus source select to the bus mux.
- mem_addr  out  AW  latched command address.
- mem_re  out  1  memory read strobe; memory has 1-cycle read latency.
- mem_we  out  1  memory write strobe; data_bus is written at mem_addr.
- acc_we  out  1  accumulator load enable.
- alu_op  out  2  ALU function: 00 PASS, 01 ADD, 10 SUB.
- err  out  1  sticky illegal-opcode flag; tied 0 when the optional feature is disabled.

Behaviour:
- Reset: one clock, synchronous, active-high; rst=1 at a rising edge resets everything.
  - State returns to IDLE; latched opcode/addr cleared to 0.
  - busy=0, done=0, mem_re=0, mem_we=0, acc_we=0, alu_op=00, dmux=DMUX_CPU, mem_addr=0, err=0.
- Opcodes:
  - 000 NOP; 001 LDC (cpu→acc); 010 LDM (mem→acc); 011 STA (acc→mem).
  - 100 ADD (acc+mem→acc); 101 SUB (acc−mem→acc); 110 WRM (cpu→mem); 111 illegal.
- States: IDLE, RD, EXEC, DONE.
- IDLE:
  - On start=1, latch opcode and addr.
  - LDM/ADD/SUB go to RD; all other opcodes go to EXEC.
- RD:
  - mem_re=1.
  - Next state EXEC, where the memory read data is valid.
- EXEC, per opcode:
  - LDC: dmux=CPU, alu_op=PASS, acc_we=1.
  - LDM: dmux=MEM, alu_op=PASS, acc_we=1.
  - ADD/SUB: dmux=MEM, alu_op=ADD/SUB, acc_we=1.
  - STA: dmux=ACC, mem_we=1.
  - WRM: dmux=CPU, mem_we=1.
  - NOP: no strobes.
  - Always goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output timing:
  - All strobes are decoded from the registered state and latched opcode.
  - Each strobe is high for exactly one cycle; no strobe is high outside its state.
  - mem_addr holds the latched addr from the cycle after start until the next accepted start.
- Latency (start sampled at edge T):
  - Non-read ops: EXEC at T+1, done at T+2.
  - LDM/ADD/SUB: RD at T+1, EXEC at T+2, done at T+3.
  - Next start is accepted the cycle after done (IDLE), giving back-to-back throughput of 3 or 4 cycles.
- Boundary conditions:
  - start while busy: ignored; no latch, no queueing.
  - start held high: a new command is accepted each time IDLE is reached.
  - rst mid-command: abort immediately; strobes drop the same edge; no done pulse.
  - dmux is DMUX_CPU in every state where it is not explicitly set.
  - mem_re and mem_we are never high in the same cycle.

Optional Feature:
- Macro: CAL_SEQ_ILLEGAL_ERR_EN.
- Defined: opcode 111 goes IDLE→DONE; no strobes; err is set and stays set until rst.
- Undefined: opcode 111 executes as NOP (EXEC→DONE); err is constant 0.

Decomposition:
- cal_head.v (shared header) holds:
  - DMUX_MEM=2'b00, DMUX_CPU=2'b01, DMUX_ACC=2'b10.
  - The opcode defines OP_NOP..OP_ILL.
  - ALU_PASS/ALU_ADD/ALU_SUB.
  - State encodings S_IDLE/S_RD/S_EXEC/S_DONE.
- No sub-module; a single always block for the state/latches plus one combinational decode block.

Test Plan:
- Reset: assert rst 2 cycles while start=1, opcode=001 → all outputs at reset values, busy=0, no strobe.
- LDC: start, opcode=001 at T → T+1: dmux=01, acc_we=1, alu_op=00; T+2: done=1; T+3: busy=0.
- ADD addr=4'h5: start at T → T+1: mem_re=1, mem_addr=5; T+2: dmux=00, alu_op=01, acc_we=1; T+3: done=1.
- STA addr=4'hF, then start pulsed at T+1 with opcode=001 → second command ignored.
  - STA itself: T+1: dmux=10, mem_we=1, mem_addr=F; T+2: done=1, with exactly one done pulse overall.
- Reset mid-op: SUB started at T, rst=1 at T+1 → T+2: state IDLE, mem_re=0, acc_we never asserted, done never asserted.
- Opcode 111:
  - With the macro defined: done at T+1, err=1 held, no strobes.
  - Without the macro: done at T+2, err=0.

Source files
------------

// File: rtl/cal_seq_pkg.sv
// Shared constants for the calculator micro-sequencer: bus-mux selects,
// opcodes, ALU functions and FSM state encodings.
package cal_seq_pkg;

    localparam int unsigned AW = 4;
    localparam int unsigned OPW = 3;
    localparam int unsigned DMW = 2;
    localparam int unsigned ALW = 2;

    // Data-bus source selects
    localparam logic [DMW-1:0] DMUX_MEM = 2'b00;
    localparam logic [DMW-1:0] DMUX_CPU = 2'b01;
    localparam logic [DMW-1:0] DMUX_ACC = 2'b10;

    // Command opcodes
    localparam logic [OPW-1:0] OP_NOP = 3'b000;
    localparam logic [OPW-1:0] OP_LDC = 3'b001;
    localparam logic [OPW-1:0] OP_LDM = 3'b010;
    localparam logic [OPW-1:0] OP_STA = 3'b011;
    localparam logic [OPW-1:0] OP_ADD = 3'b100;
    localparam logic [OPW-1:0] OP_SUB = 3'b101;
    localparam logic [OPW-1:0] OP_WRM = 3'b110;
    localparam logic [OPW-1:0] OP_ILL = 3'b111;

    // ALU functions
    localparam logic [ALW-1:0] ALU_PASS = 2'b00;
    localparam logic [ALW-1:0] ALU_ADD  = 2'b01;
    localparam logic [ALW-1:0] ALU_SUB  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // True for opcodes that need a memory read before execution
    function automatic logic needs_read(input logic [OPW-1:0] op);
        return (op == OP_LDM) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cal_seq_if.sv
// Command and datapath-control bundle between the command source and cal_seq.
interface cal_seq_if;
    import cal_seq_pkg::*;

    logic                start;
    logic [OPW-1:0]      opcode;
    logic [AW-1:0]       addr;
    logic                busy;
    logic                done;
    logic [DMW-1:0]      dmux;
    logic [AW-1:0]       mem_addr;
    logic                mem_re;
    logic                mem_we;
    logic                acc_we;
    logic [ALW-1:0]      alu_op;
    logic                err;

    modport master (
        output start, opcode, addr,
        input  busy, done, dmux, mem_addr, mem_re, mem_we, acc_we, alu_op, err
    );

    modport slave (
        input  start, opcode, addr,
        output busy, done, dmux, mem_addr, mem_re, mem_we, acc_we, alu_op, err
    );

endinterface

// File: rtl/cal_seq.sv
// Calculator micro-sequencer: accepts one command at a time and sequences the
// dmux / memory strobes / accumulator load for it.
// Optional build macro: CAL_SEQ_ILLEGAL_ERR_EN -- opcode 111 skips straight to
// DONE and raises a sticky err flag; otherwise 111 behaves as NOP and err is 0.
module cal_seq
    import cal_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    cal_seq_if.slave   bus
);

    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
    logic            err_q, err_d;
`endif

    logic            busy_c;
    logic            done_c;
    logic [DMW-1:0]  dmux_c;
    logic            mem_re_c;
    logic            mem_we_c;
    logic            acc_we_c;
    logic [ALW-1:0]  alu_op_c;

    // State and command latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OPW'(0);
            addr_q  <= AW'(0);
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and command acceptance
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.opcode;
                    addr_d = bus.addr;
                    if (needs_read(bus.opcode)) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_EXEC;
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
                        if (bus.opcode == OP_ILL) begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            S_RD:    state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode from registered state and latched opcode
    always_comb begin
        busy_c   = (state_q != S_IDLE);
        done_c   = (state_q == S_DONE);
        mem_re_c = (state_q == S_RD);
        mem_we_c = 1'b0;
        acc_we_c = 1'b0;
        alu_op_c = ALU_PASS;
        dmux_c   = DMUX_CPU;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_LDC: begin
                    acc_we_c = 1'b1;
                end
                OP_LDM: begin
                    dmux_c   = DMUX_MEM;
                    acc_we_c = 1'b1;
                end
                OP_ADD: begin
                    dmux_c   = DMUX_MEM;
                    alu_op_c = ALU_ADD;
                    acc_we_c = 1'b1;
                end
                OP_SUB: begin
                    dmux_c   = DMUX_MEM;
                    alu_op_c = ALU_SUB;
                    acc_we_c = 1'b1;
                end
                OP_STA: begin
                    dmux_c   = DMUX_ACC;
                    mem_we_c = 1'b1;
                end
                OP_WRM: begin
                    mem_we_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.dmux     = dmux_c;
    assign bus.mem_addr = addr_q;
    assign bus.mem_re   = mem_re_c;
    assign bus.mem_we   = mem_we_c;
    assign bus.acc_we   = acc_we_c;
    assign bus.alu_op   = alu_op_c;
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_cal_seq.sv
// Directed testbench for cal_seq; expectations follow the build macro
// CAL_SEQ_ILLEGAL_ERR_EN for opcode 111.
module tb_cal_seq;
    import cal_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    cal_seq_if bus();

    cal_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] op, input logic [3:0] a);
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.addr   = a;
        step();
        bus.start  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   32'(bus.busy),   32'd0);
        chk({tag, "_done"},   32'(bus.done),   32'd0);
        chk({tag, "_dmux"},   32'(bus.dmux),   32'(DMUX_CPU));
        chk({tag, "_acc_we"}, 32'(bus.acc_we), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_re"}, 32'(bus.mem_re), 32'd0);
    endtask

    // Read and write strobes must never overlap
    always @(negedge clk) begin
        chk("re_we_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
    end

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.opcode = 3'b001;
        bus.addr   = 4'h0;

        // Reset held two cycles with start asserted
        step();
        step();
        chk_idle("rst");
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_alu_op",   32'(bus.alu_op),   32'd0);
        chk("rst_err",      32'(bus.err),      32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        chk_idle("post_rst");

        // LDC
        go(3'b001, 4'h3);
        chk("ldc_busy",   32'(bus.busy),   32'd1);
        chk("ldc_dmux",   32'(bus.dmux),   32'h1);
        chk("ldc_acc_we", 32'(bus.acc_we), 32'd1);
        chk("ldc_alu",    32'(bus.alu_op), 32'h0);
        chk("ldc_mem_re", 32'(bus.mem_re), 32'd0);
        step();
        chk("ldc_done",   32'(bus.done),   32'd1);
        chk("ldc_acc_we_off", 32'(bus.acc_we), 32'd0);
        step();
        chk_idle("ldc_end");

        // ADD from address 5
        go(3'b100, 4'h5);
        chk("add_mem_re",   32'(bus.mem_re),   32'd1);
        chk("add_mem_addr", 32'(bus.mem_addr), 32'h5);
        chk("add_acc_we0",  32'(bus.acc_we),   32'd0);
        chk("add_dmux_rd",  32'(bus.dmux),     32'(DMUX_CPU));
        step();
        chk("add_dmux",     32'(bus.dmux),     32'h0);
        chk("add_alu",      32'(bus.alu_op),   32'h1);
        chk("add_acc_we",   32'(bus.acc_we),   32'd1);
        chk("add_mem_re0",  32'(bus.mem_re),   32'd0);
        step();
        chk("add_done",     32'(bus.done),     32'd1);
        step();
        chk_idle("add_end");

        // STA to F with a second start pulsed while busy
        go(3'b011, 4'hF);
        chk("sta_dmux",     32'(bus.dmux),     32'h2);
        chk("sta_mem_we",   32'(bus.mem_we),   32'd1);
        chk("sta_mem_addr", 32'(bus.mem_addr), 32'hF);
        chk("sta_acc_we",   32'(bus.acc_we),   32'd0);
        bus.start  = 1'b1;
        bus.opcode = 3'b001;
        bus.addr   = 4'h2;
        step();
        bus.start  = 1'b0;
        chk("sta_done",     32'(bus.done),     32'd1);
        chk("sta_mem_we0",  32'(bus.mem_we),   32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("sta_ignored");
            chk("sta_addr_hold", 32'(bus.mem_addr), 32'hF);
        end

        // SUB aborted by reset in RD
        go(3'b101, 4'h7);
        chk("sub_mem_re",   32'(bus.mem_re),   32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("sub_abort");
        chk("sub_abort_addr", 32'(bus.mem_addr), 32'd0);
        step();
        chk_idle("sub_abort2");

        // WRM and LDM
        go(3'b110, 4'h9);
        chk("wrm_dmux",   32'(bus.dmux),   32'h1);
        chk("wrm_mem_we", 32'(bus.mem_we), 32'd1);
        chk("wrm_acc_we", 32'(bus.acc_we), 32'd0);
        step();
        chk("wrm_done",   32'(bus.done),   32'd1);
        step();
        go(3'b010, 4'h2);
        chk("ldm_mem_re", 32'(bus.mem_re), 32'd1);
        step();
        chk("ldm_dmux",   32'(bus.dmux),   32'h0);
        chk("ldm_alu",    32'(bus.alu_op), 32'h0);
        chk("ldm_acc_we", 32'(bus.acc_we), 32'd1);
        step();
        chk("ldm_done",   32'(bus.done),   32'd1);
        step();

        // start held high on NOP: new command every 3 cycles
        bus.start  = 1'b1;
        bus.opcode = 3'b000;
        step();
        chk("nop_busy1", 32'(bus.busy), 32'd1);
        chk("nop_strb",  32'(bus.acc_we | bus.mem_we | bus.mem_re), 32'd0);
        step();
        chk("nop_done",  32'(bus.done), 32'd1);
        step();
        chk("nop_idle",  32'(bus.busy), 32'd0);
        step();
        chk("nop_again", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        step();
        step();
        chk_idle("nop_end");

        // Illegal opcode
        go(3'b111, 4'h4);
`ifdef CAL_SEQ_ILLEGAL_ERR_EN
        chk("ill_done",  32'(bus.done), 32'd1);
        chk("ill_err",   32'(bus.err),  32'd1);
        chk("ill_strb",  32'(bus.acc_we | bus.mem_we | bus.mem_re), 32'd0);
        step();
        chk_idle("ill_end");
        chk("ill_err_hold", 32'(bus.err), 32'd1);
`else
        chk("ill_busy",  32'(bus.busy), 32'd1);
        chk("ill_done0", 32'(bus.done), 32'd0);
        chk("ill_strb",  32'(bus.acc_we | bus.mem_we | bus.mem_re), 32'd0);
        chk("ill_err",   32'(bus.err),  32'd0);
        step();
        chk("ill_done",  32'(bus.done), 32'd1);
        step();
        chk_idle("ill_end");
        chk("ill_err_end", 32'(bus.err), 32'd0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_cleared", 32'(bus.err), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
